// File: rtl/conv_row_feeder.sv
// 3x3 convolution row feeder: raster pixels in, column-aligned row triples out.
// Two line buffers hold rows r-2 and r-1; optional zero ring and vertical stride-2.
module conv_row_feeder #(
   parameter int unsigned PEA_NUM = 4,
   parameter int unsigned DW      = 8,
   parameter int unsigned MAX_COL = 256,
   parameter int unsigned MAX_ROW = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [8:0]              cfg_col,
   input  logic [8:0]              cfg_row,
   input  logic                    cfg_pad,
   input  logic                    cfg_stride2,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [PEA_NUM*DW-1:0]   in_data,
   output logic                    out_valid,
   output logic [PEA_NUM*DW-1:0]   data1,
   output logic [PEA_NUM*DW-1:0]   data2,
   output logic [PEA_NUM*DW-1:0]   data3,
   output logic [8:0]              out_row,
   output logic [8:0]              out_col,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    cfg_err
);

   localparam int unsigned W        = PEA_NUM * DW;
   localparam int unsigned LB_DEPTH = MAX_COL + 2;
   localparam logic [9:0]  MAX_COL_L = 10'(MAX_COL);
   localparam logic [9:0]  MAX_ROW_L = 10'(MAX_ROW);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e       state_q, state_d;
   logic [8:0]   rows_q, rows_d;
   logic [8:0]   cols_q, cols_d;
   logic         pad_q, pad_d;
   logic         s2_q, s2_d;
   logic [8:0]   prow_q, prow_d;
   logic [8:0]   pcol_q, pcol_d;
   logic         out_valid_q, out_valid_d;
   logic         frame_done_q, frame_done_d;
   logic         cfg_err_q, cfg_err_d;
   logic [W-1:0] data1_q, data1_d;
   logic [W-1:0] data2_q, data2_d;
   logic [W-1:0] data3_q, data3_d;
   logic [8:0]   out_row_q, out_row_d;
   logic [8:0]   out_col_q, out_col_d;

   // Line buffers are never cleared: rows 0-1 of each frame emit nothing.
   logic [W-1:0] lb_a_q [LB_DEPTH];
   logic [W-1:0] lb_b_q [LB_DEPTH];
   logic [W-1:0] lb_a_rd, lb_b_rd;

   logic [9:0]   r_ext, c_ext;
   logic         legal;
   logic         pad_pos;
   logic         adv;
   logic         last_col, last_row;
   logic [W-1:0] v;

   always_comb begin
      r_ext = {1'b0, cfg_row} + (cfg_pad ? 10'd2 : 10'd0);
      c_ext = {1'b0, cfg_col} + (cfg_pad ? 10'd2 : 10'd0);
      legal = (cfg_col != 9'd0) && ({1'b0, cfg_col} <= MAX_COL_L) &&
              (cfg_row != 9'd0) && ({1'b0, cfg_row} <= MAX_ROW_L) &&
              (r_ext >= 10'd3) && (c_ext >= 10'd3);
   end

   always_comb begin
      last_col = (pcol_q == cols_q - 9'd1);
      last_row = (prow_q == rows_q - 9'd1);
      pad_pos  = pad_q && ((prow_q == 9'd0) || last_row || (pcol_q == 9'd0) || last_col);
      in_ready = (state_q == S_RUN) && !pad_pos;
      adv      = (state_q == S_RUN) && (pad_pos || in_valid);
      v        = pad_pos ? '0 : in_data;
      lb_a_rd  = lb_a_q[pcol_q];
      lb_b_rd  = lb_b_q[pcol_q];
   end

   always_comb begin
      state_d      = state_q;
      rows_d       = rows_q;
      cols_d       = cols_q;
      pad_d        = pad_q;
      s2_d         = s2_q;
      prow_d       = prow_q;
      pcol_d       = pcol_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      cfg_err_d    = 1'b0;
      data1_d      = data1_q;
      data2_d      = data2_q;
      data3_d      = data3_q;
      out_row_d    = out_row_q;
      out_col_d    = out_col_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (legal) begin
                  state_d = S_RUN;
                  rows_d  = r_ext[8:0];
                  cols_d  = c_ext[8:0];
                  pad_d   = cfg_pad;
                  s2_d    = cfg_stride2;
                  prow_d  = '0;
                  pcol_d  = '0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (adv) begin
               data3_d     = v;
               data2_d     = lb_b_rd;
               data1_d     = lb_a_rd;
               out_valid_d = (prow_q >= 9'd2) && (!s2_q || !prow_q[0]);
               out_row_d   = prow_q - 9'd2;
               out_col_d   = pcol_q;
               if (last_col) begin
                  pcol_d = '0;
                  if (last_row) begin
                     prow_d       = '0;
                     state_d      = S_DONE;
                     frame_done_d = 1'b1;
                  end else begin
                     prow_d = prow_q + 9'd1;
                  end
               end else begin
                  pcol_d = pcol_q + 9'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rows_q       <= '0;
         cols_q       <= '0;
         pad_q        <= 1'b0;
         s2_q         <= 1'b0;
         prow_q       <= '0;
         pcol_q       <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         data1_q      <= '0;
         data2_q      <= '0;
         data3_q      <= '0;
         out_row_q    <= '0;
         out_col_q    <= '0;
      end else begin
         state_q      <= state_d;
         rows_q       <= rows_d;
         cols_q       <= cols_d;
         pad_q        <= pad_d;
         s2_q         <= s2_d;
         prow_q       <= prow_d;
         pcol_q       <= pcol_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
         data1_q      <= data1_d;
         data2_q      <= data2_d;
         data3_q      <= data3_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         lb_a_q[pcol_q] <= lb_b_rd;
         lb_b_q[pcol_q] <= v;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign cfg_err    = cfg_err_q;
   assign data1      = data1_q;
   assign data2      = data2_q;
   assign data3      = data3_q;
   assign out_row    = out_row_q;
   assign out_col    = out_col_q;

endmodule

// File: doc/conv_row_feeder.md
# conv_row_feeder

Parametrised 3x3 convolution row feeder that sits between the DRAM-side input stream and the CCM array, replacing the fixed 4-lane, fixed-size row-window path. It accepts raster-order pixels (PEA_NUM independent 8-bit lanes per beat) and keeps two line buffers. It emits row-aligned triples (data1/data2/data3 = rows r-2, r-1, r) for every column. Per frame it generates optional zero padding and optional vertical stride-2 decimation, all configured at run time.

## Interface
- PEA_NUM, 4, parallel lanes (channels) per beat
- DW, 8, bits per lane
- MAX_COL, 256, largest supported cfg_col (unpadded)
- MAX_ROW, 256, largest supported cfg_row (unpadded)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start; latches cfg_*; ignored while busy
- cfg_col  in  9  unpadded columns per row
- cfg_row  in  9  unpadded rows per frame
- cfg_pad  in  1  1 = add a one-pixel zero ring
- cfg_stride2  in  1  1 = emit only every second output row
- in_valid  in  1  input beat valid
- in_ready  out  1  feeder accepts beat this cycle
- in_data  in  PEA_NUM*DW  one pixel per lane
- out_valid  out  1  data1/2/3 valid this cycle (no backpressure)
- data1 / data2 / data3  out  PEA_NUM*DW each  rows r-2 / r-1 / r at out_col
- out_row  out  9  output row index (prow-2)
- out_col  out  9  padded column index pcol
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse with last output beat
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- Padded geometry: R = cfg_row+2*cfg_pad, C = cfg_col+2*cfg_pad. Counters prow 0..R-1, pcol 0..C-1, raster order.
- Legal config: cfg_col 1..MAX_COL and cfg_row 1..MAX_ROW, with R>=3 and C>=3. Otherwise start pulses cfg_err and the block stays IDLE.
- FSM: IDLE -> RUN on legal start; RUN -> DONE on advance of (R-1,C-1); DONE -> IDLE next cycle.
- Pad position: cfg_pad && (prow==0 || prow==R-1 || pcol==0 || pcol==C-1). Value v = 0, advances every RUN cycle, consumes no input.
- Real position: advances only on in_valid && in_ready, with v = in_data. in_ready = (state==RUN) && position is real.
- Per advance at pcol: data3<=v, data2<=lbB[pcol], data1<=lbA[pcol]; lbA[pcol]<=lbB[pcol], lbB[pcol]<=v. Line buffers are C entries deep (max MAX_COL+2) and are not cleared.
- out_valid<=1 on an advance with prow>=2 and (!cfg_stride2 || prow[0]==0, i.e. prow-2 even). out_row<=prow-2, out_col<=pcol.
- Lanes are fully independent; no arithmetic across lanes.

## Timing
- Reset: state IDLE; in_ready, out_valid, busy, frame_done, cfg_err, data1/2/3, out_row, out_col all 0; counters 0.
- busy rises the cycle after a legal start and falls the cycle after frame_done.
- Latency: outputs are registered one cycle after the advancing cycle (accept edge for real positions).
- Stall: while in_valid=0 at a real position, no advance and out_valid=0; outputs hold their last values.
- start during busy: ignored, cfg unchanged. start in DONE: ignored.
- frame_done asserts in the same cycle as the out_valid for (R-1,C-1). In stride-2 mode with R-1 odd, frame_done asserts alone with out_valid=0.
- Reset mid-frame: immediate return to reset values. Stale line-buffer data is never emitted, because rows 0-1 of a new frame produce no output.
- Input throughput is 1 beat/cycle. Pad beats add exactly 2R+2C-4 cycles per padded frame.

## Test plan
- No pad, 1 lane, 4x4, pixel=16*r+c, in_valid always 1 -> 8 out beats. At out_row0/col1: data1=0x01, data2=0x11, data3=0x21. frame_done with out_row1/col3.
- Pad 3x3, pixel=1..9 -> 15 out beats. out_row0/col0 is all zeros. out_row0/col1: data1=0, data2=1, data3=4. in_ready low on the 16 pad positions.
- Stride2, no pad, 4 lanes, 5x4 -> only prow 2 and 4 emitted (8 beats); lanes carry distinct values and do not mix.
- Random in_valid gaps on the 4x4 case -> identical output sequence; out_valid never high without a preceding accept.
- Illegal: cfg_col=2, cfg_pad=0 -> cfg_err pulse, busy stays 0. Then start during busy -> ignored.
- Assert rst_n low mid-frame, then a new 4x4 frame -> outputs match the first scenario exactly.
